// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline buffer: FSM states,
// control-word bit positions and default widths.
package ex_mem_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    localparam int MEM_WR = 0;
    localparam int MEM_RD = 1;
    localparam int REG_WR = 8;
    localparam int WB_LSB = 8;

    localparam int DW_DEF = 16;
    localparam int RW_DEF = 4;

endpackage

// File: rtl/ex_mem_buf.sv
// EX/MEM pipeline register built as a 2-entry skid buffer (head + skid),
// with forwarding outputs for the hazard unit and a saturating stall counter.
module ex_mem_buf
    import ex_mem_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          out_ready,
    input  logic [DW-1:0] in_alu_result,
    input  logic [DW-1:0] in_store_data,
    input  logic [15:0]   in_cntrl_mem,
    input  logic [RW-1:0] in_dest_reg,
    input  logic          in_flush,
    input  logic          in_mem_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_alu_result,
    output logic [DW-1:0] out_store_data,
    output logic [15:0]   out_cntrl_wb,
    output logic          out_mem_rd,
    output logic          out_mem_wr,
    output logic [RW-1:0] out_dest_reg,
    output logic [DW-1:0] out_mem_haz,
    output logic [RW-1:0] out_haz_dest,
    output logic          out_haz_valid,
    output logic [7:0]    out_stall_cnt
);

    buf_state_e state_q, state_d;
    logic       accept, pop;
    logic       load_head_in, load_skid, skid_to_head;

    logic [DW-1:0] head_alu_q, head_sd_q, skid_alu_q, skid_sd_q;
    logic [7:0]    head_wb_q, skid_wb_q;
    logic          head_rd_q, head_wr_q, skid_rd_q, skid_wr_q;
    logic [RW-1:0] head_dest_q, skid_dest_q;
    logic [7:0]    stall_cnt_q, stall_cnt_d;

    // Bits between the memory strobes and the WB byte carry nothing downstream.
    logic unused_cntrl;
    assign unused_cntrl = ^in_cntrl_mem[WB_LSB-1:MEM_RD+1];

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        load_head_in = 1'b0;
        load_skid    = 1'b0;
        skid_to_head = 1'b0;
        if (in_flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d      = ONE;
                        load_head_in = 1'b1;
                    end
                end
                ONE: begin
                    case ({accept, pop})
                        2'b11:   load_head_in = 1'b1;
                        2'b10: begin
                            state_d   = FULL;
                            load_skid = 1'b1;
                        end
                        2'b01:   state_d = EMPTY;
                        default: state_d = ONE;
                    endcase
                end
                FULL: begin
                    if (pop) begin
                        state_d      = ONE;
                        skid_to_head = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_ready = (state_q != FULL);
        out_valid = (state_q != EMPTY);
        accept    = in_valid & out_ready;
        pop       = out_valid & in_mem_ready;
    end

    // Data registers only move on accept or skid->head, so a stalled head is stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_alu_q  <= '0;
            head_sd_q   <= '0;
            head_wb_q   <= '0;
            head_rd_q   <= 1'b0;
            head_wr_q   <= 1'b0;
            head_dest_q <= '0;
            skid_alu_q  <= '0;
            skid_sd_q   <= '0;
            skid_wb_q   <= '0;
            skid_rd_q   <= 1'b0;
            skid_wr_q   <= 1'b0;
            skid_dest_q <= '0;
        end else begin
            if (load_head_in) begin
                head_alu_q  <= in_alu_result;
                head_sd_q   <= in_store_data;
                head_wb_q   <= in_cntrl_mem[WB_LSB+7:WB_LSB];
                head_rd_q   <= in_cntrl_mem[MEM_RD];
                head_wr_q   <= in_cntrl_mem[MEM_WR];
                head_dest_q <= in_dest_reg;
            end else if (skid_to_head) begin
                head_alu_q  <= skid_alu_q;
                head_sd_q   <= skid_sd_q;
                head_wb_q   <= skid_wb_q;
                head_rd_q   <= skid_rd_q;
                head_wr_q   <= skid_wr_q;
                head_dest_q <= skid_dest_q;
            end
            if (load_skid) begin
                skid_alu_q  <= in_alu_result;
                skid_sd_q   <= in_store_data;
                skid_wb_q   <= in_cntrl_mem[WB_LSB+7:WB_LSB];
                skid_rd_q   <= in_cntrl_mem[MEM_RD];
                skid_wr_q   <= in_cntrl_mem[MEM_WR];
                skid_dest_q <= in_dest_reg;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !in_mem_ready && stall_cnt_q != 8'hFF)
            stall_cnt_d = stall_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign out_alu_result = head_alu_q;
    assign out_store_data = head_sd_q;
    assign out_cntrl_wb   = {8'b0, head_wb_q};
    assign out_mem_rd     = out_valid & head_rd_q;
    assign out_mem_wr     = out_valid & head_wr_q;
    assign out_dest_reg   = head_dest_q;
    // Loads can't forward from EX/MEM: their data isn't available yet.
    assign out_haz_valid  = out_valid & head_wb_q[REG_WR-WB_LSB] & ~head_rd_q;
    assign out_mem_haz    = head_alu_q;
    assign out_haz_dest   = head_dest_q;
    assign out_stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_buf.sv
// Self-checking bench for ex_mem_buf: directed scenarios plus a random phase,
// all compared against a queue-based FIFO reference model.
module tb_ex_mem_buf;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_flush, in_mem_ready;
    logic [15:0] in_alu_result, in_store_data, in_cntrl_mem;
    logic [3:0]  in_dest_reg;
    logic        out_ready, out_valid, out_mem_rd, out_mem_wr, out_haz_valid;
    logic [15:0] out_alu_result, out_store_data, out_cntrl_wb, out_mem_haz;
    logic [3:0]  out_dest_reg, out_haz_dest;
    logic [7:0]  out_stall_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ex_mem_buf #(.DW(16), .RW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .out_ready(out_ready),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .in_cntrl_mem(in_cntrl_mem), .in_dest_reg(in_dest_reg),
        .in_flush(in_flush), .in_mem_ready(in_mem_ready),
        .out_valid(out_valid), .out_alu_result(out_alu_result),
        .out_store_data(out_store_data), .out_cntrl_wb(out_cntrl_wb),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_dest_reg(out_dest_reg), .out_mem_haz(out_mem_haz),
        .out_haz_dest(out_haz_dest), .out_haz_valid(out_haz_valid),
        .out_stall_cnt(out_stall_cnt)
    );

    typedef struct packed {
        logic [15:0] alu;
        logic [15:0] sd;
        logic [15:0] ctl;
        logic [3:0]  dest;
    } ent_t;

    ent_t q[$];     // entries in flight, oldest first (at most 2)
    ent_t disp;     // what the head registers currently hold
    int   m_cnt;

    // Reference: compute the effect of the upcoming clock edge from the current inputs.
    task automatic model_step();
        bit v, rdy;
        ent_t e;
        v   = (q.size() != 0);
        rdy = (q.size() < 2);
        if (!rst_n) begin
            q.delete();
            disp  = '0;
            m_cnt = 0;
            return;
        end
        if (v && !in_mem_ready && m_cnt < 255) m_cnt++;
        if (in_flush) begin
            q.delete();
        end else begin
            if (v && in_mem_ready) void'(q.pop_front());
            if (in_valid && rdy) begin
                e = '{alu: in_alu_result, sd: in_store_data, ctl: in_cntrl_mem, dest: in_dest_reg};
                q.push_back(e);
            end
        end
        if (q.size() != 0) disp = q[0];
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        bit v;
        v = (q.size() != 0);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".ready"}, 32'(out_ready), 32'(q.size() < 2));
        chk({tag, ".stall"}, 32'(out_stall_cnt), 32'(m_cnt));
        chk({tag, ".alu"}, 32'(out_alu_result), 32'(disp.alu));
        chk({tag, ".sd"}, 32'(out_store_data), 32'(disp.sd));
        chk({tag, ".wb"}, 32'(out_cntrl_wb), 32'({8'h00, disp.ctl[15:8]}));
        chk({tag, ".rd"}, 32'(out_mem_rd), 32'(v & disp.ctl[1]));
        chk({tag, ".wr"}, 32'(out_mem_wr), 32'(v & disp.ctl[0]));
        chk({tag, ".dest"}, 32'(out_dest_reg), 32'(disp.dest));
        chk({tag, ".haz"}, 32'(out_mem_haz), 32'(disp.alu));
        chk({tag, ".hazd"}, 32'(out_haz_dest), 32'(disp.dest));
        chk({tag, ".hazv"}, 32'(out_haz_valid), 32'(v & disp.ctl[8] & ~disp.ctl[1]));
    endtask

    task automatic drive(logic v, logic [15:0] alu, logic [15:0] ctl, logic mr);
        in_valid      = v;
        in_alu_result = alu;
        in_store_data = ~alu;
        in_cntrl_mem  = ctl;
        in_dest_reg   = alu[3:0] ^ 4'h5;
        in_mem_ready  = mr;
    endtask

    task automatic tick(string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_flush = 1'b0;
        drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        tick("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] vals [20];

        // Reset state: empty, ready, everything zero.
        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(out_ready), 32'd1);
        chk("rst_alu", 32'(out_alu_result), 32'd0);
        chk("rst_cnt", 32'(out_stall_cnt), 32'd0);

        // Single accept, one-cycle latency, forwarding qualified.
        drive(1'b1, 16'h0F0F, 16'h0100, 1'b1);
        tick("lat");
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_alu", 32'(out_alu_result), 32'h0F0F);
        chk("lat_hazv", 32'(out_haz_valid), 32'd1);
        chk("lat_wb", 32'(out_cntrl_wb), 32'h0001);
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        tick("lat_drain");

        // Fill to FULL, then drain in order.
        drive(1'b1, 16'h0001, 16'h0100, 1'b0);
        tick("full_a");
        drive(1'b1, 16'h0002, 16'h0100, 1'b0);
        tick("full_b");
        chk("full_ready", 32'(out_ready), 32'd0);
        chk("full_head", 32'(out_alu_result), 32'h0001);
        drive(1'b1, 16'h0003, 16'h0100, 1'b0);
        tick("full_blocked");
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        tick("pop_a");
        chk("pop_a_head", 32'(out_alu_result), 32'h0002);
        tick("pop_b");
        chk("pop_b_valid", 32'(out_valid), 32'd0);

        // Load entry: mem_rd suppresses forwarding.
        drive(1'b1, 16'h1234, 16'h0102, 1'b0);
        tick("load");
        chk("load_rd", 32'(out_mem_rd), 32'd1);
        chk("load_hazv", 32'(out_haz_valid), 32'd0);

        // Flush from FULL with a same-cycle input.
        drive(1'b1, 16'h5555, 16'h0001, 1'b0);
        tick("fl_fill");
        chk("fl_ready0", 32'(out_ready), 32'd0);
        in_flush = 1'b1;
        drive(1'b1, 16'h6666, 16'h0001, 1'b0);
        tick("flush");
        in_flush = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(out_ready), 32'd1);
        chk("flush_wr", 32'(out_mem_wr), 32'd0);
        chk("flush_keep", 32'(out_alu_result), 32'h1234);

        // Stall counter saturation and reset.
        do_reset();
        drive(1'b1, 16'hAAAA, 16'h0000, 1'b0);
        tick("stall_ld");
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 300; i++) tick("stall");
        chk("stall_sat", 32'(out_stall_cnt), 32'd255);
        do_reset();
        chk("stall_rst", 32'(out_stall_cnt), 32'd0);
        chk("stall_rst_valid", 32'(out_valid), 32'd0);

        // Continuous streaming.
        for (int i = 0; i < 20; i++) vals[i] = 16'($urandom);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, vals[i], 16'h0100, 1'b1);
            tick("stream");
            chk("stream_alu", 32'(out_alu_result), 32'(vals[i]));
            chk("stream_ready", 32'(out_ready), 32'd1);
        end

        // Random traffic against the model, with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            rst_n    = ($urandom_range(0, 63) != 0);
            in_flush = ($urandom_range(0, 15) == 0);
            drive(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
